// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and limits for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_t;

  localparam int MAX_LOAD_LATENCY = 7;
  localparam int LAT_CNT_W        = $clog2(MAX_LOAD_LATENCY + 1);

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic                  load_e, reg_write_m, reg_write_w, pc_src_e, mem_busy_m;
  logic [1:0]            forward_a_e, forward_b_e;
  logic                  stall_f, stall_d, stall_e, stall_m;
  logic                  flush_d, flush_e, flush_w;
  logic [CNT_W-1:0]      stall_cycles, flush_count;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output load_e, reg_write_m, reg_write_w, pc_src_e, mem_busy_m,
    input  forward_a_e, forward_b_e,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  load_e, reg_write_m, reg_write_w, pc_src_e, mem_busy_m,
    output forward_a_e, forward_b_e,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// rtl/hazard_ctrl_fwd_select.sv - E-stage bypass select for one source operand
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output fwd_sel_t              sel_o
);

  // M is checked first because it carries the younger write to the same register.
  always_comb begin
    sel_o = FWD_RF;
    if ((rs_i != '0) && (rs_i == rd_m_i) && reg_write_m_i) begin
      sel_o = FWD_MEM;
    end else if ((rs_i != '0) && (rs_i == rd_w_i) && reg_write_w_i) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush control and hazard counters for the 5-stage pipe
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  hz_state_t            state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]     flush_count_q, flush_count_d;
  hz_ctrl_t             ctrl;
  fwd_sel_t             fwd_a, fwd_b;
  logic                 load_use;
  logic                 branch_flush;

  assign load_use = hz.load_e && (hz.rd_e != '0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // A memory wait outranks the branch, so the redirect is only taken once M is free.
  assign branch_flush = (state_q == RUN) && !hz.mem_busy_m && hz.pc_src_e;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i          (hz.rs1_e),
    .rd_m_i        (hz.rd_m),
    .rd_w_i        (hz.rd_w),
    .reg_write_m_i (hz.reg_write_m),
    .reg_write_w_i (hz.reg_write_w),
    .sel_o         (fwd_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i          (hz.rs2_e),
    .rd_m_i        (hz.rd_m),
    .rd_w_i        (hz.rd_w),
    .reg_write_m_i (hz.reg_write_m),
    .reg_write_w_i (hz.reg_write_w),
    .sel_o         (fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!hz.mem_busy_m) begin
      case (state_q)
        RUN: begin
          // The first bubble is spent in RUN, so LOAD_STALL covers the remaining LOAD_LATENCY-1.
          if (!hz.pc_src_e && load_use && (LOAD_LATENCY > 1)) begin
            state_d = LOAD_STALL;
            cnt_d   = LAT_CNT_W'(LOAD_LATENCY - 2);
          end
        end
        LOAD_STALL: begin
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (ctrl.stall_f && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (branch_flush && !(&flush_count_q)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      if (hz.mem_busy_m) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.stall_e = 1'b1;
        ctrl.stall_m = 1'b1;
        ctrl.flush_w = 1'b1;
      end else if (state_q == LOAD_STALL) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end else if (hz.pc_src_e) begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end else if (load_use) begin
        ctrl.stall_f = 1'b1;
        ctrl.stall_d = 1'b1;
        ctrl.flush_e = 1'b1;
      end
    end
  end

  assign hz.forward_a_e  = rst_n ? fwd_a : FWD_RF;
  assign hz.forward_b_e  = rst_n ? fwd_b : FWD_RF;
  assign hz.stall_f      = ctrl.stall_f;
  assign hz.stall_d      = ctrl.stall_d;
  assign hz.stall_e      = ctrl.stall_e;
  assign hz.stall_m      = ctrl.stall_m;
  assign hz.flush_d      = ctrl.flush_d;
  assign hz.flush_e      = ctrl.flush_e;
  assign hz.flush_w      = ctrl.flush_w;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench: four latency/width variants against a reference model
module tb_hazard_ctrl;

  localparam int NI = 4;
  localparam int LL_TAB[NI] = '{1, 3, 5, 7};
  localparam int CW_TAB[NI] = '{16, 16, 4, 4};

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        sf, sd, se, sm, fd, fe, fw;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;
  typedef exp_t [NI-1:0] exp4_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       load_e, reg_write_m, reg_write_w, pc_src_e, mem_busy_m;

  exp_t  act [NI];
  exp4_t sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc_no = 0;

  int left_m [NI];
  int sc_m   [NI];
  int fc_m   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CW_TAB[g])) bus ();

    hazard_ctrl #(
      .REG_ADDR_W   (5),
      .LOAD_LATENCY (LL_TAB[g]),
      .CNT_W        (CW_TAB[g])
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (bus.slave)
    );

    assign bus.rs1_d       = rs1_d;
    assign bus.rs2_d       = rs2_d;
    assign bus.rs1_e       = rs1_e;
    assign bus.rs2_e       = rs2_e;
    assign bus.rd_e        = rd_e;
    assign bus.rd_m        = rd_m;
    assign bus.rd_w        = rd_w;
    assign bus.load_e      = load_e;
    assign bus.reg_write_m = reg_write_m;
    assign bus.reg_write_w = reg_write_w;
    assign bus.pc_src_e    = pc_src_e;
    assign bus.mem_busy_m  = mem_busy_m;

    assign act[g] = {bus.forward_a_e, bus.forward_b_e,
                     bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                     bus.flush_d, bus.flush_e, bus.flush_w,
                     16'(bus.stall_cycles), 16'(bus.flush_count)};
  end

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 0 && rs == rd_m && reg_write_m) return 2'b10;
    if (rs != 0 && rs == rd_w && reg_write_w) return 2'b01;
    return 2'b00;
  endfunction

  // Reference: a load hazard owes LOAD_LATENCY bubbles; memory-wait cycles do not pay them off.
  task automatic model_push();
    exp4_t e4;
    bit    lu, flushed;
    int    maxv;
    lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      e = '0;
      flushed = 1'b0;
      maxv = (1 << CW_TAB[i]) - 1;
      if (!rst_n) begin
        left_m[i] = 0;
        sc_m[i]   = 0;
        fc_m[i]   = 0;
      end else begin
        e.fa = ref_fwd(rs1_e);
        e.fb = ref_fwd(rs2_e);
        if (mem_busy_m) begin
          {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
        end else if (left_m[i] > 0) begin
          {e.sf, e.sd, e.fe} = 3'b111;
          left_m[i]--;
        end else if (pc_src_e) begin
          {e.fd, e.fe} = 2'b11;
          flushed = 1'b1;
        end else if (lu) begin
          {e.sf, e.sd, e.fe} = 3'b111;
          left_m[i] = LL_TAB[i] - 1;
        end
      end
      e.sc = 16'(sc_m[i]);
      e.fc = 16'(fc_m[i]);
      if (rst_n) begin
        if (e.sf && sc_m[i] < maxv) sc_m[i]++;
        if (flushed && fc_m[i] < maxv) fc_m[i]++;
      end
      e4[i] = e;
    end
    sb_q.push_back(e4);
  endtask

  task automatic cyc(input logic r, input logic [4:0] a1d, a2d, a1e, a2e, rde, rdm, rdw,
                     input logic le, wm, ww, pc, mb);
    @(posedge clk);
    #1;
    rst_n = r;
    rs1_d = a1d; rs2_d = a2d; rs1_e = a1e; rs2_e = a2e;
    rd_e = rde; rd_m = rdm; rd_w = rdw;
    load_e = le; reg_write_m = wm; reg_write_w = ww; pc_src_e = pc; mem_busy_m = mb;
    cyc_no++;
    model_push();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp4_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (act[i] !== e[i]) begin
            failures++;
            $display("FAIL inst%0d_ll%0d cycle=%0d actual=%h expected=%h",
                     i, LL_TAB[i], cyc_no, act[i], e[i]);
          end
        end
      end
    end
  end

  initial begin : stim
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mem_busy_m = 0;
    cyc(0, 7, 7, 5, 5, 7, 5, 5, 1, 1, 1, 1, 1);
    cyc(0, 7, 7, 5, 5, 7, 5, 5, 1, 1, 1, 0, 0);
    // forwarding priority and x0 filter
    cyc(1, 0, 0, 5, 5, 0, 5, 5, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 5, 6, 0, 5, 5, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // plain load-use, then drain
    cyc(1, 0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    idle(8);
    // load-use with a two-cycle memory wait in the second stall cycle
    cyc(1, 0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(8);
    // taken branch masks load-use
    cyc(1, 7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0);
    idle(2);
    // reset mid-stall, then a fresh hazard
    cyc(1, 3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    idle(8);
    // long stall run to saturate the narrow counters
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 2));
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Second-generation hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W). It produces the E-stage forwarding selects and the per-stage stall and flush controls, and it adds behaviour the first generation lacked:
- x0 filtering on forwarding
- load-use stalls of parametrised length
- data-memory wait stalls
- branch flushes
- saturating hazard performance counters

It sits beside the datapath and drives the pipeline-register enables and clears.

Parameters:
REG_ADDR_W, 5, register-index width
LOAD_LATENCY, 1, load-use bubble count; legal range 1..7
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
rs1_d  in  REG_ADDR_W  D-stage source 1
rs2_d  in  REG_ADDR_W  D-stage source 2
rs1_e  in  REG_ADDR_W  E-stage source 1
rs2_e  in  REG_ADDR_W  E-stage source 2
rd_e  in  REG_ADDR_W  E-stage destination
rd_m  in  REG_ADDR_W  M-stage destination
rd_w  in  REG_ADDR_W  W-stage destination
load_e  in  1  E-stage instruction is a load
reg_write_m  in  1  M-stage writes the register file
reg_write_w  in  1  W-stage writes the register file
pc_src_e  in  1  branch or jump taken, resolved in E
mem_busy_m  in  1  data memory not ready; M must hold
forward_a_e  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
forward_b_e  out  2  operand B select, same encoding as forward_a_e
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
stall_e  out  1  hold D/E register
stall_m  out  1  hold E/M register
flush_d  out  1  clear F/D register
flush_e  out  1  clear D/E register
flush_w  out  1  clear M/W register (inject bubble)
stall_cycles  out  CNT_W  cycles with stall_f=1, saturating
flush_count  out  CNT_W  taken-branch flushes, saturating

Clock, reset and timing:
- Single clock `clk`; reset `rst_n` is asynchronous and active-low.
- Forwarding and control outputs are combinational from the inputs plus the registered FSM state.
- Counters are registered.

Forwarding (per operand; identical for B with rs2_e):
- If rs1_e != 0 and rs1_e == rd_m and reg_write_m, select 10 (M has priority: it holds the newer value).
- Else if rs1_e != 0 and rs1_e == rd_w and reg_write_w, select 01.
- Else select 00.
- Forwarding is never suppressed by stalls.

Hazard conditions:
- load_use = load_e & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d)

FSM states and transitions:
- RUN, priority order:
  1. mem_busy_m: stall_f/d/e/m = 1 and flush_w = 1; all other controls 0; stay in RUN.
  2. pc_src_e: flush_d = flush_e = 1 for one cycle; load_use is ignored (D is being flushed).
  3. load_use: stall_f = stall_d = 1 and flush_e = 1. If LOAD_LATENCY > 1, go to LOAD_STALL with cnt = LOAD_LATENCY-2.
- LOAD_STALL:
  - Outputs: stall_f = stall_d = flush_e = 1.
  - If cnt == 0, go to RUN; else cnt decrements.
  - mem_busy_m overrides: all of stall_f/d/e/m = 1, flush_w = 1, flush_e = 0, and cnt and state freeze.
  - pc_src_e cannot assert here (E holds a bubble); if it does, ignore it.
- Total bubbles per load-use hazard = LOAD_LATENCY exactly.

Performance counters:
- stall_cycles increments on every cycle where stall_f = 1.
- flush_count increments on every cycle where pc_src_e causes a flush.
- Both saturate at all-ones and never wrap.

Reset:
- While rst_n = 0: state = RUN, cnt = 0, counters = 0, all stall/flush outputs 0, forward selects 00.
- Reset asserted mid-LOAD_STALL or mid-mem wait aborts the stall immediately, asynchronously.

Decomposition:
- hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - hz_state_t enum: RUN, LOAD_STALL
  - MAX_LOAD_LATENCY = 7
- One natural sub-module, fwd_select: it takes one source index plus rd_m/rd_w/write-enables and returns fwd_sel_t. Instantiate it twice (operands A and B).

Test Plan:
- rs1_e = 5, rd_m = 5, reg_write_m = 1, rd_w = 5, reg_write_w = 1 -> forward_a_e = 10. Then reg_write_m = 0 -> 01. Then rs1_e = 0 -> 00.
- LOAD_LATENCY = 1: load_e = 1, rd_e = 7, rs2_d = 7 -> exactly one cycle of stall_f = stall_d = flush_e = 1; stall_cycles goes 0 -> 1.
- LOAD_LATENCY = 3: same hazard -> stall_f = 1 for exactly 3 cycles, FSM back in RUN on cycle 4. Then raise mem_busy_m for 2 cycles in the second stall cycle -> total stall_f cycles = 5, flush_w = 1 for those 2 cycles.
- pc_src_e = 1 together with a load_use condition -> flush_d = flush_e = 1, stall_f = 0, flush_count = 1.
- Preload counters near max via CNT_W = 4, 20 stall cycles -> stall_cycles holds at 15.
- rst_n low for one cycle mid-LOAD_STALL (LOAD_LATENCY = 5) -> all controls 0 immediately; counters 0; next load_use restarts with a full 5-cycle stall.
